// File: rtl/roi_pkg.sv
// Shared types and defaults for the ROI bounding-box tracker.
// Optional centroid sums are enabled by ROI_BBOX_CENTROID_EN.
package roi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    CAPTURE,
    DONE
  } state_t;

  localparam int IMG_W_DEF = 320;
  localparam int IMG_H_DEF = 240;
  localparam int CNT_W_DEF = 10;

endpackage

// File: rtl/roi_row_accum.sv
// Per-row white count, column limits and optional x-sum for the ROI tracker.
// ROI_BBOX_CENTROID_EN adds the per-row x-sum and unsaturated pixel count.
module roi_row_accum #(
  parameter int X_W   = 12,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             pix,
  input  logic             white,
  input  logic             eor,
  input  logic [X_W-1:0]   x,
  output logic [CNT_W-1:0] cnt,
  output logic [X_W-1:0]   x_min,
  output logic [X_W-1:0]   x_max
`ifdef ROI_BBOX_CENTROID_EN
  ,
  output logic [2*X_W-1:0] x_sum,
  output logic [X_W:0]     npix
`endif
);

  logic [CNT_W-1:0] r_cnt;
  logic [X_W-1:0]   r_min;
  logic [X_W-1:0]   r_max;
  logic [CNT_W-1:0] b_cnt;
  logic [X_W-1:0]   b_min;
  logic [X_W-1:0]   b_max;
  logic             hit;
  logic             first;

  assign hit = pix && white;

  // A frame restart discards the stored row before this beat's pixel lands.
  always_comb begin
    b_cnt = clr ? '0 : r_cnt;
    b_min = clr ? '0 : r_min;
    b_max = clr ? '0 : r_max;
    first = (b_cnt == '0);
    cnt   = b_cnt;
    x_min = b_min;
    x_max = b_max;
    if (hit) begin
      if (b_cnt != '1) cnt = b_cnt + 1'b1;
      if (first || x < b_min) x_min = x;
      if (first || x > b_max) x_max = x;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || eor) begin
      r_cnt <= '0;
      r_min <= '0;
      r_max <= '0;
    end else begin
      r_cnt <= cnt;
      r_min <= x_min;
      r_max <= x_max;
    end
  end

`ifdef ROI_BBOX_CENTROID_EN
  logic [2*X_W-1:0] r_sum;
  logic [X_W:0]     r_npix;
  logic [2*X_W-1:0] b_sum;
  logic [X_W:0]     b_npix;

  always_comb begin
    b_sum  = clr ? '0 : r_sum;
    b_npix = clr ? '0 : r_npix;
    x_sum  = hit ? b_sum + {{X_W{1'b0}}, x} : b_sum;
    npix   = hit ? b_npix + 1'b1 : b_npix;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || eor) begin
      r_sum  <= '0;
      r_npix <= '0;
    end else begin
      r_sum  <= x_sum;
      r_npix <= npix;
    end
  end
`endif

endmodule

// File: rtl/roi_bbox_tracker.sv
// Per-frame qualifying-row bounding box and peak row count on the BW stream.
// Centroid sums are built only when ROI_BBOX_CENTROID_EN is defined.
module roi_bbox_tracker
  import roi_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int X_W   = 12,
  parameter int Y_W   = 12,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic                   iSTART,
  input  logic                   iNewFrame,
  input  logic                   iDATA,
  input  logic                   iDVAL,
  input  logic [CNT_W-1:0]       iTHRESH,
  output logic                   oBUSY,
  output logic                   oDONE,
  output logic                   oFOUND,
  output logic                   oERR,
  output logic [X_W-1:0]         oX_MIN,
  output logic [X_W-1:0]         oX_MAX,
  output logic [Y_W-1:0]         oY_MIN,
  output logic [Y_W-1:0]         oY_MAX,
  output logic [CNT_W-1:0]       oROW_MAX,
  output logic [Y_W-1:0]         oROW_MAX_Y,
  output logic [X_W+Y_W+X_W-1:0] oSUM_X,
  output logic [X_W+Y_W+Y_W-1:0] oSUM_Y,
  output logic [X_W+Y_W-1:0]     oPIX_CNT
);

  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

  state_t         state;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [X_W-1:0] x_eff;
  logic [Y_W-1:0] y_eff;
  logic           in_frame;
  logic           restart;
  logic           pix;
  logic           eor;
  logic           last;
  logic           start_ok;
  logic           qual;

  logic [CNT_W-1:0] rc;
  logic [X_W-1:0]   rxmin;
  logic [X_W-1:0]   rxmax;

  logic             n_found;
  logic [X_W-1:0]   n_xmin;
  logic [X_W-1:0]   n_xmax;
  logic [Y_W-1:0]   n_ymin;
  logic [Y_W-1:0]   n_ymax;
  logic [CNT_W-1:0] n_rmax;
  logic [Y_W-1:0]   n_rmy;

  assign in_frame = (state == ARM) || (state == CAPTURE);
  assign start_ok = iSTART && ((state == IDLE) || (state == DONE));
  assign restart  = iNewFrame && in_frame;
  assign pix      = iDVAL && ((state == CAPTURE) || restart);
  assign x_eff    = restart ? '0 : x;
  assign y_eff    = restart ? '0 : y;
  assign eor      = pix && (x_eff == X_LAST);
  assign last     = eor && (y_eff == Y_LAST);
  assign qual     = (rc >= iTHRESH) && (rc != '0);

`ifdef ROI_BBOX_CENTROID_EN
  logic [2*X_W-1:0]         rxsum;
  logic [X_W:0]             rnpix;
  logic [X_W+Y_W+X_W-1:0]   n_sx;
  logic [X_W+Y_W+Y_W-1:0]   n_sy;
  logic [X_W+Y_W-1:0]       n_pc;
`endif

  roi_row_accum #(
    .X_W   (X_W),
    .CNT_W (CNT_W)
  ) u_row (
    .clk   (iCLK),
    .rst_n (iRST),
    .clr   (restart),
    .pix   (pix),
    .white (iDATA),
    .eor   (eor),
    .x     (x_eff),
    .cnt   (rc),
    .x_min (rxmin),
    .x_max (rxmax)
`ifdef ROI_BBOX_CENTROID_EN
    ,
    .x_sum (rxsum),
    .npix  (rnpix)
`endif
  );

  // Next-result view: restart clears first, then this beat's end-of-row commits.
  always_comb begin
    n_found = restart ? 1'b0 : oFOUND;
    n_xmin  = restart ? '0 : oX_MIN;
    n_xmax  = restart ? '0 : oX_MAX;
    n_ymin  = restart ? '0 : oY_MIN;
    n_ymax  = restart ? '0 : oY_MAX;
    n_rmax  = restart ? '0 : oROW_MAX;
    n_rmy   = restart ? '0 : oROW_MAX_Y;
    if (eor) begin
      if (qual) begin
        if (!n_found || rxmin < n_xmin) n_xmin = rxmin;
        if (!n_found || rxmax > n_xmax) n_xmax = rxmax;
        if (!n_found) n_ymin = y_eff;
        n_ymax  = y_eff;
        n_found = 1'b1;
      end
      if (rc > n_rmax) begin
        n_rmax = rc;
        n_rmy  = y_eff;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state <= IDLE;
      oBUSY <= 1'b0;
      oDONE <= 1'b0;
      oERR  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (iSTART) begin
            state <= ARM;
            oBUSY <= 1'b1;
            oDONE <= 1'b0;
            oERR  <= 1'b0;
          end
        end
        ARM: begin
          if (iNewFrame) begin
            state <= last ? DONE : CAPTURE;
            oBUSY <= !last;
            oDONE <= last;
          end
        end
        CAPTURE: begin
          if (iNewFrame) oERR <= 1'b1;
          if (last) begin
            state <= DONE;
            oBUSY <= 1'b0;
            oDONE <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST || start_ok) begin
      x          <= '0;
      y          <= '0;
      oFOUND     <= 1'b0;
      oX_MIN     <= '0;
      oX_MAX     <= '0;
      oY_MIN     <= '0;
      oY_MAX     <= '0;
      oROW_MAX   <= '0;
      oROW_MAX_Y <= '0;
    end else if (in_frame) begin
      oFOUND     <= n_found;
      oX_MIN     <= n_xmin;
      oX_MAX     <= n_xmax;
      oY_MIN     <= n_ymin;
      oY_MAX     <= n_ymax;
      oROW_MAX   <= n_rmax;
      oROW_MAX_Y <= n_rmy;
      if (pix) begin
        x <= eor ? '0 : x_eff + 1'b1;
        y <= eor ? y_eff + 1'b1 : y_eff;
      end else if (restart) begin
        x <= '0;
        y <= '0;
      end
    end
  end

`ifdef ROI_BBOX_CENTROID_EN
  always_comb begin
    n_sx = restart ? '0 : oSUM_X;
    n_sy = restart ? '0 : oSUM_Y;
    n_pc = restart ? '0 : oPIX_CNT;
    if (eor && qual) begin
      n_sx = n_sx + (X_W+Y_W+X_W)'(rxsum);
      n_sy = n_sy + (X_W+Y_W+Y_W)'(y_eff) * (X_W+Y_W+Y_W)'(rnpix);
      n_pc = n_pc + (X_W+Y_W)'(rnpix);
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST || start_ok) begin
      oSUM_X   <= '0;
      oSUM_Y   <= '0;
      oPIX_CNT <= '0;
    end else if (in_frame) begin
      oSUM_X   <= n_sx;
      oSUM_Y   <= n_sy;
      oPIX_CNT <= n_pc;
    end
  end
`else
  assign oSUM_X   = '0;
  assign oSUM_Y   = '0;
  assign oPIX_CNT = '0;
`endif

endmodule

// File: tb/tb_roi_bbox_tracker.sv
// Directed bench for roi_bbox_tracker: 8x4 frames plus one 320x240 white frame.
// Centroid expectations follow ROI_BBOX_CENTROID_EN.
module tb_roi_bbox_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;

  logic       s_start = 0, s_nf = 0, s_data = 0, s_dval = 0;
  logic [9:0] s_th = '0;
  logic       s_busy, s_done, s_found, s_err;
  logic [3:0] s_xmin, s_xmax, s_ymin, s_ymax, s_rmy;
  logic [9:0] s_rmax;
  logic [11:0] s_sx, s_sy;
  logic [7:0] s_pc;

  logic        l_start = 0, l_nf = 0, l_data = 0, l_dval = 0;
  logic [7:0]  l_th = '0;
  logic        l_busy, l_done, l_found, l_err;
  logic [11:0] l_xmin, l_xmax, l_ymin, l_ymax, l_rmy;
  logic [7:0]  l_rmax;
  logic [35:0] l_sx, l_sy;
  logic [23:0] l_pc;

  int nvec = 0;
  int nerr = 0;

  roi_bbox_tracker #(
    .IMG_W(8), .IMG_H(4), .X_W(4), .Y_W(4), .CNT_W(10)
  ) dut_s (
    .iCLK(clk), .iRST(rst), .iSTART(s_start), .iNewFrame(s_nf),
    .iDATA(s_data), .iDVAL(s_dval), .iTHRESH(s_th),
    .oBUSY(s_busy), .oDONE(s_done), .oFOUND(s_found), .oERR(s_err),
    .oX_MIN(s_xmin), .oX_MAX(s_xmax), .oY_MIN(s_ymin), .oY_MAX(s_ymax),
    .oROW_MAX(s_rmax), .oROW_MAX_Y(s_rmy),
    .oSUM_X(s_sx), .oSUM_Y(s_sy), .oPIX_CNT(s_pc)
  );

  roi_bbox_tracker #(
    .IMG_W(320), .IMG_H(240), .X_W(12), .Y_W(12), .CNT_W(8)
  ) dut_l (
    .iCLK(clk), .iRST(rst), .iSTART(l_start), .iNewFrame(l_nf),
    .iDATA(l_data), .iDVAL(l_dval), .iTHRESH(l_th),
    .oBUSY(l_busy), .oDONE(l_done), .oFOUND(l_found), .oERR(l_err),
    .oX_MIN(l_xmin), .oX_MAX(l_xmax), .oY_MIN(l_ymin), .oY_MAX(l_ymax),
    .oROW_MAX(l_rmax), .oROW_MAX_Y(l_rmy),
    .oSUM_X(l_sx), .oSUM_Y(l_sy), .oPIX_CNT(l_pc)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic row_s(input logic [7:0] b, input logic nf0);
    for (int i = 0; i < 8; i++) begin
      s_data = b[i];
      s_dval = 1'b1;
      s_nf   = nf0 && (i == 0);
      tick();
    end
    s_dval = 0;
    s_data = 0;
    s_nf   = 0;
  endtask

  task automatic arm_s();
    s_start = 1;
    tick();
    s_start = 0;
    s_nf = 1;
    tick();
    s_nf = 0;
  endtask

  task automatic res_s(input string t, input logic f,
                       input int xmn, input int xmx,
                       input int ymn, input int ymx,
                       input int rm, input int rmy,
                       input int sx, input int sy, input int pc);
    check({t, ".done"}, s_done, 1);
    check({t, ".busy"}, s_busy, 0);
    check({t, ".found"}, s_found, f);
    check({t, ".xmin"}, s_xmin, xmn);
    check({t, ".xmax"}, s_xmax, xmx);
    check({t, ".ymin"}, s_ymin, ymn);
    check({t, ".ymax"}, s_ymax, ymx);
    check({t, ".rmax"}, s_rmax, rm);
    check({t, ".rmy"}, s_rmy, rmy);
`ifdef ROI_BBOX_CENTROID_EN
    check({t, ".sumx"}, s_sx, sx);
    check({t, ".sumy"}, s_sy, sy);
    check({t, ".pix"}, s_pc, pc);
`else
    check({t, ".sumx"}, s_sx, 0);
    check({t, ".sumy"}, s_sy, 0);
    check({t, ".pix"}, s_pc, 0);
`endif
  endtask

  localparam logic [7:0] P  = 8'b0011_1100;
  localparam logic [7:0] Z  = 8'b0000_0000;
  localparam logic [7:0] HI = 8'b1100_0000;
  localparam logic [7:0] LO = 8'b0000_0011;

  initial begin
    tick();
    tick();
    rst = 1;
    tick();

    check("rst.busy", s_busy, 0);
    check("rst.done", s_done, 0);
    check("rst.found", s_found, 0);
    check("rst.err", s_err, 0);
    check("rst.xmin", s_xmin, 0);
    check("rst.rmax", s_rmax, 0);
    check("rst.l_done", l_done, 0);
    check("rst.l_xmin", l_xmin, 0);

    // threshold 2, rows 1-2 white at x=2..5
    s_th = 2;
    s_start = 1;
    tick();
    s_start = 0;
    check("t1.arm_busy", s_busy, 1);
    s_nf = 1;
    tick();
    s_nf = 0;
    row_s(Z, 0);
    row_s(P, 0);
    row_s(P, 0);
    check("t1.mid_done", s_done, 0);
    row_s(Z, 0);
    res_s("t1", 1, 2, 5, 1, 2, 4, 1, 28, 12, 8);

    // DONE ignores pixels and frame starts
    s_nf = 1;
    s_dval = 1;
    s_data = 1;
    tick();
    s_nf = 0;
    s_dval = 0;
    s_data = 0;
    tick();
    res_s("t1h", 1, 2, 5, 1, 2, 4, 1, 28, 12, 8);

    // threshold 5: nothing qualifies but the peak is still tracked
    s_th = 5;
    s_start = 1;
    tick();
    s_start = 0;
    check("t2.clr_done", s_done, 0);
    check("t2.clr_found", s_found, 0);
    check("t2.clr_rmax", s_rmax, 0);
    s_nf = 1;
    tick();
    s_nf = 0;
    row_s(Z, 0);
    row_s(P, 0);
    row_s(P, 0);
    row_s(Z, 0);
    res_s("t2", 0, 0, 0, 0, 0, 4, 1, 0, 0, 0);

    // threshold 0 on an all-black frame
    s_th = 0;
    arm_s();
    repeat (4) row_s(Z, 0);
    res_s("t3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // short frame, then a restart coinciding with the first pixel
    s_th = 2;
    arm_s();
    row_s(HI, 0);
    row_s(HI, 0);
    row_s(LO, 1);
    check("t4.err", s_err, 1);
    check("t4.busy", s_busy, 1);
    row_s(Z, 0);
    row_s(P, 0);
    row_s(Z, 0);
    res_s("t4", 1, 0, 5, 0, 2, 4, 2, 15, 8, 6);
    check("t4.err_hold", s_err, 1);

    // new start clears the sticky error
    s_start = 1;
    tick();
    s_start = 0;
    check("t5.err_clr", s_err, 0);
    check("t5.done_clr", s_done, 0);
    check("t5.busy", s_busy, 1);
    s_nf = 1;
    tick();
    s_nf = 0;

    // start during capture is ignored; reset mid-frame returns to idle
    row_s(P, 0);
    s_start = 1;
    tick();
    s_start = 0;
    check("t6.busy", s_busy, 1);
    check("t6.xmin", s_xmin, 2);
    check("t6.xmax", s_xmax, 5);
    check("t6.found", s_found, 1);
    row_s(P, 0);
    s_dval = 1;
    s_data = 1;
    tick();
    rst = 0;
    tick();
    rst = 1;
    s_dval = 0;
    s_data = 0;
    check("t6r.busy", s_busy, 0);
    check("t6r.done", s_done, 0);
    check("t6r.found", s_found, 0);
    check("t6r.err", s_err, 0);
    check("t6r.xmin", s_xmin, 0);
    check("t6r.xmax", s_xmax, 0);
    check("t6r.ymin", s_ymin, 0);
    check("t6r.ymax", s_ymax, 0);
    check("t6r.rmax", s_rmax, 0);
    check("t6r.rmy", s_rmy, 0);
    check("t6r.sumx", s_sx, 0);
    check("t6r.pix", s_pc, 0);
    tick();
    check("t6r.idle", s_busy, 0);

    // full-size all-white frame, 8-bit saturating row count
    l_th = 1;
    l_start = 1;
    tick();
    l_start = 0;
    l_nf = 1;
    tick();
    l_nf = 0;
    l_dval = 1;
    l_data = 1;
    repeat (320 * 240) tick();
    l_dval = 0;
    l_data = 0;
    check("big.done", l_done, 1);
    check("big.found", l_found, 1);
    check("big.err", l_err, 0);
    check("big.rmax", l_rmax, 255);
    check("big.rmy", l_rmy, 0);
    check("big.xmin", l_xmin, 0);
    check("big.xmax", l_xmax, 319);
    check("big.ymin", l_ymin, 0);
    check("big.ymax", l_ymax, 239);
`ifdef ROI_BBOX_CENTROID_EN
    check("big.pix", l_pc, 76800);
    check("big.sumx", l_sx, 12249600);
    check("big.sumy", l_sy, 9177600);
`else
    check("big.pix", l_pc, 0);
    check("big.sumx", l_sx, 0);
    check("big.sumy", l_sy, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
